segdisplay_reader: RTL and testbench

//  Receive-side counterpart of the 4-digit multiplexed seven-segment driver.

---
 rtl/segdisplay_reader.sv | 161 ++++++++++++++++
 tb/tb_segdisplay_reader.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/segdisplay_reader.sv
// Snoops a multiplexed active-low 4-digit seven-segment bus, debounces and decodes
// each scanned digit, and converts a complete frame to a binary value (0..9999).
module segdisplay_reader #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg_in,
    output logic [15:0] num_out,
    output logic        num_valid,
    output logic        digit_err,
    output logic        blank,
    output logic        busy
);
    localparam int SW = (STABLE_CYCLES  > 2) ? $clog2(STABLE_CYCLES)  : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {COLLECT, CONVERT, DONE} state_t;

    state_t          state;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;
    logic [SW-1:0]   stab_cnt;
    logic            taken;
    logic [TW-1:0]   tcnt;
    logic [3:0][3:0] digit_q;
    logic [3:0]      seen, bad;
    logic [16:0]     acc;
    logic [1:0]      step;

    logic            pair_chg, accept, stab_full, t_expired;
    logic [1:0]      sel;
    logic [4:0]      dec;
    logic [3:0]      seen_n, bad_n;
    logic [16:0]     acc_n;

    // Active-low segment decode; bit 4 of the result flags a non-decimal pattern.
    function automatic logic [4:0] dec7(input logic [6:0] s);
        case (s)
            7'b1000000: dec7 = 5'd0;
            7'b1111001: dec7 = 5'd1;
            7'b0100100: dec7 = 5'd2;
            7'b0110000: dec7 = 5'd3;
            7'b0011001: dec7 = 5'd4;
            7'b0010010: dec7 = 5'd5;
            7'b0000010: dec7 = 5'd6;
            7'b1111000: dec7 = 5'd7;
            7'b0000000: dec7 = 5'd8;
            7'b0010000: dec7 = 5'd9;
            default:    dec7 = 5'b10000;
        endcase
    endfunction

    always_comb begin
        pair_chg  = ({an, seg_in} != {an_q, seg_q});
        stab_full = (stab_cnt == SW'(STABLE_CYCLES - 1));
        t_expired = (tcnt == TW'(TIMEOUT_CYCLES - 1));
        accept    = stab_full && !taken && $onehot(~an_q);
        sel = 2'd0;
        for (int i = 0; i < 4; i++)
            if (!an_q[i]) sel = 2'(i);
        dec    = dec7(seg_q);
        seen_n = seen;
        bad_n  = bad;
        if (accept) begin
            seen_n[sel] = 1'b1;
            bad_n[sel]  = dec[4];
        end
        // step 0..3 walks digit3 down to digit0, so ~step is the digit index
        acc_n = (acc << 3) + (acc << 1) + {13'd0, digit_q[~step]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COLLECT;
            an_q      <= 4'hF;
            seg_q     <= 7'h7F;
            stab_cnt  <= '0;
            taken     <= 1'b0;
            tcnt      <= '0;
            digit_q   <= '0;
            seen      <= '0;
            bad       <= '0;
            acc       <= '0;
            step      <= '0;
            num_out   <= '0;
            num_valid <= 1'b0;
            digit_err <= 1'b0;
            blank     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            an_q  <= an;
            seg_q <= seg_in;
            // Stability tracking runs in every state; taken blocks re-accepting a held pair.
            if (pair_chg) begin
                stab_cnt <= '0;
                taken    <= 1'b0;
            end else if (stab_full) begin
                taken <= 1'b1;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end

            num_valid <= 1'b0;
            digit_err <= 1'b0;

            case (state)
                COLLECT: begin
                    if (accept) begin
                        digit_q[sel] <= dec[3:0];
                        tcnt         <= '0;
                        blank        <= 1'b0;
                    end else if (t_expired) begin
                        blank <= 1'b1;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end

                    if (!accept && t_expired) begin
                        seen <= '0;
                        bad  <= '0;
                    end else if (seen_n == 4'hF && bad_n != 4'h0) begin
                        digit_err <= 1'b1;
                        seen      <= '0;
                        bad       <= '0;
                    end else if (seen_n == 4'hF) begin
                        seen  <= seen_n;
                        bad   <= bad_n;
                        acc   <= '0;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end else begin
                        seen <= seen_n;
                        bad  <= bad_n;
                    end
                end
                CONVERT: begin
                    acc  <= acc_n;
                    step <= step + 1'b1;
                    if (step == 2'd3) begin
                        num_out   <= acc_n[15:0];
                        num_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    seen  <= '0;
                    bad   <= '0;
                    tcnt  <= '0;
                    busy  <= 1'b0;
                    state <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_segdisplay_reader.sv
// Directed bench for segdisplay_reader: drives scan frames on the anode/segment
// bus and checks decoded values, pulse counts, blank and reset behaviour.
module tb_segdisplay_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg_in;
    logic [15:0] num_out;
    logic        num_valid, digit_err, blank, busy;

    int checks = 0;
    int errs   = 0;
    int vcnt   = 0;
    int ecnt   = 0;
    logic [6:0] seg_tab [10];

    segdisplay_reader #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .seg_in(seg_in),
        .num_out(num_out), .num_valid(num_valid), .digit_err(digit_err),
        .blank(blank), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (num_valid) vcnt++;
        if (digit_err) ecnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic show_raw(input int d, input logic [6:0] s, input int n);
        an     = ~(4'b0001 << d);
        seg_in = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        an     = 4'hF;
        seg_in = 7'h7F;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int d3, input int d2, input int d1, input int d0);
        show_raw(3, seg_tab[d3], 8);
        show_raw(2, seg_tab[d2], 8);
        show_raw(1, seg_tab[d1], 8);
        show_raw(0, seg_tab[d0], 8);
        idle(10);
    endtask

    initial begin
        int  n;
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;

        rst_n = 1'b0; an = 4'hF; seg_in = 7'h7F;
        repeat (3) @(negedge clk);
        chk("rst_num_out", num_out, 0);
        chk("rst_valid", num_valid, 0);
        chk("rst_err", digit_err, 0);
        chk("rst_blank", blank, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(2);

        // basic frame 1234
        vcnt = 0;
        frame(1, 2, 3, 4);
        chk("t1_num", num_out, 16'd1234);
        chk("t1_vcnt", vcnt, 1);

        // extremes
        vcnt = 0;
        frame(0, 0, 0, 0);
        chk("t2a_num", num_out, 16'h0000);
        chk("t2a_vcnt", vcnt, 1);
        vcnt = 0;
        frame(9, 9, 9, 9);
        chk("t2b_num", num_out, 16'h270F);
        chk("t2b_vcnt", vcnt, 1);

        // short glitch on digit 2 must not complete the frame early
        vcnt = 0;
        show_raw(3, seg_tab[5], 8);
        show_raw(1, seg_tab[7], 8);
        show_raw(0, seg_tab[8], 8);
        show_raw(2, seg_tab[9], 2);
        show_raw(2, seg_tab[6], 8);
        idle(10);
        chk("t3_num", num_out, 16'd5678);
        chk("t3_vcnt", vcnt, 1);

        // non-decimal pattern discards the frame
        vcnt = 0; ecnt = 0;
        show_raw(3, seg_tab[1], 8);
        show_raw(2, 7'b1111111, 8);
        show_raw(1, seg_tab[3], 8);
        show_raw(0, seg_tab[4], 8);
        idle(10);
        chk("t4_ecnt", ecnt, 1);
        chk("t4_vcnt", vcnt, 0);
        chk("t4_num", num_out, 16'd5678);

        // timeout then recovery
        idle(80);
        chk("t5_blank_set", blank, 1);
        vcnt = 0;
        show_raw(3, seg_tab[0], 8);
        chk("t5_blank_clr", blank, 0);
        show_raw(2, seg_tab[0], 8);
        show_raw(1, seg_tab[4], 8);
        show_raw(0, seg_tab[2], 8);
        idle(10);
        chk("t5_num", num_out, 16'd42);
        chk("t5_vcnt", vcnt, 1);

        // reset in the middle of CONVERT
        vcnt = 0;
        show_raw(3, seg_tab[3], 8);
        show_raw(2, seg_tab[1], 8);
        show_raw(1, seg_tab[4], 8);
        an = 4'b1110; seg_in = seg_tab[1];
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_busy_seen", busy, 1);
        rst_n = 1'b0;
        an = 4'hF; seg_in = 7'h7F;
        @(negedge clk);
        chk("t6_rst_num", num_out, 0);
        chk("t6_rst_valid", num_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_blank", blank, 0);
        chk("t6_rst_err", digit_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        chk("t6_no_valid", vcnt, 0);
        frame(0, 7, 1, 9);
        chk("t6_num", num_out, 16'd719);
        chk("t6_vcnt", vcnt, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
